// File: rtl/four_bit_reload_sequencer_if.sv
// Bundle between the reload sequencer, its controller and the 4-bit loadable up-counter.
// Latency: none (wires only).
// Backpressure: none; start/stop are single-cycle requests, load/in go straight to the counter.
//
// Signals: start/stop requests, cfg_start/cfg_term/cfg_reps window setup,
// q_in counter feedback, load/in counter drive, busy/done/wraps/err status.
interface four_bit_reload_sequencer_if #(
    parameter int REP_W = 8
);
    logic             start;
    logic             stop;
    logic [3:0]       cfg_start;
    logic [3:0]       cfg_term;
    logic [REP_W-1:0] cfg_reps;
    logic [3:0]       q_in;
    logic             load;
    logic [3:0]       in;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] wraps;
    logic             err;

    // The sequencer drives the counter and reports status.
    modport master (
        input  start, stop, cfg_start, cfg_term, cfg_reps, q_in,
        output load, in, busy, done, wraps, err
    );

    // Controller/counter side.
    modport slave (
        output start, stop, cfg_start, cfg_term, cfg_reps, q_in,
        input  load, in, busy, done, wraps, err
    );
endinterface

// File: rtl/four_bit_reload_sequencer.sv
// Drives a 4-bit loadable counter through the window start..term (mod 16), counts periods, checks Q.
// Latency: load/busy/done/wraps/err registered (1 cycle); in is combinational from state and config.
// Backpressure: none; start is honoured only in IDLE, stop only in RUN, config is frozen during a run.
//
// Ports: clk, clear (sync active-high, shared with the counter), bus (master modport of
// four_bit_reload_sequencer_if carrying requests, config, counter feedback and status).
module four_bit_reload_sequencer #(
    parameter int REP_W = 8
) (
    input  logic                           clk,
    input  logic                           clear,
    four_bit_reload_sequencer_if.master    bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic             load_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [REP_W-1:0] wraps_r;
    logic [REP_W-1:0] reps_r;
    logic [3:0]       start_r;
    logic [3:0]       term_r;
    logic [3:0]       exp_r;

    logic [3:0]       in_d;
    logic [3:0]       nq;
    logic [REP_W-1:0] wraps_inc;
    logic [REP_W-1:0] wraps_sat;
    logic             reps_hit;

    // While idle the counter follows the live config so it is ready at cfg_start.
    assign in_d = (state == IDLE) ? bus.cfg_start : start_r;

    // Model of what the counter will show after the coming edge.
    assign nq = load_r ? in_d : exp_r + 4'd1;

    assign wraps_inc = wraps_r + REP_W'(1);
    assign wraps_sat = (&wraps_r) ? wraps_r : wraps_inc;
    assign reps_hit  = (reps_r != '0) && (wraps_inc == reps_r);

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            load_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            wraps_r <= '0;
            reps_r  <= '0;
            start_r <= '0;
            term_r  <= '0;
            exp_r   <= '0;
        end else begin
            exp_r  <= nq;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        start_r <= bus.cfg_start;
                        term_r  <= bus.cfg_term;
                        reps_r  <= bus.cfg_reps;
                        wraps_r <= '0;
                        state   <= RUN;
                        busy_r  <= 1'b1;
                        // load is high in IDLE, so nq is cfg_start; compare with the term being captured.
                        load_r  <= (nq == bus.cfg_term);
                    end else begin
                        load_r  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.q_in != exp_r) begin
                        err_r <= 1'b1;
                    end
                    // load high means the counter is showing term_r: a period completes on this edge.
                    if (load_r) begin
                        wraps_r <= wraps_sat;
                    end
                    if (load_r && reps_hit) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        load_r <= 1'b1;
                    end else if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        load_r <= 1'b1;
                    end else begin
                        load_r <= (nq == term_r);
                    end
                end
                default: begin
                    state  <= IDLE;
                    load_r <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load  = load_r;
    assign bus.in    = in_d;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.wraps = wraps_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_four_bit_reload_sequencer.sv
module tb_four_bit_reload_sequencer;

    localparam int REP_W = 8;

    logic       clk;
    logic       clear;
    logic [3:0] cnt_q;
    logic       force_en;
    logic [3:0] force_val;

    int vectors;
    int miscompares;

    four_bit_reload_sequencer_if #(.REP_W(REP_W)) intf ();

    four_bit_reload_sequencer #(.REP_W(REP_W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit loadable up-counter; q_in can be overridden to inject a bad value.
    always @(posedge clk) begin
        if (clear)          cnt_q <= 4'd0;
        else if (intf.load) cnt_q <= intf.in;
        else                cnt_q <= cnt_q + 4'd1;
    end
    assign intf.q_in = force_en ? force_val : cnt_q;

    task automatic pulse_start();
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (intf.load !== 1'b1) begin miscompares++; $display("FAIL reset_load got %0b want 1", intf.load); end
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", intf.busy); end
        vectors++; if (intf.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", intf.done); end
        vectors++; if (intf.wraps !== 8'd0) begin miscompares++; $display("FAIL reset_wraps got %0d want 0", intf.wraps); end
        vectors++; if (intf.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", intf.err); end
        vectors++; if (intf.q_in !== 4'd0) begin miscompares++; $display("FAIL reset_q got %0d want 0", intf.q_in); end
        clear = 1'b0;
        @(negedge clk);
        vectors++; if (intf.q_in !== 4'd3) begin miscompares++; $display("FAIL idle_pin got %0d want 3", intf.q_in); end
        vectors++; if (intf.in !== 4'd3) begin miscompares++; $display("FAIL idle_in got %0d want 3", intf.in); end
    endtask

    task automatic test_basic_window();
        logic [3:0] eq [8];
        logic       el [8];
        eq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd3, 4'd4, 4'd5, 4'd6};
        el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        intf.cfg_start = 4'd3; intf.cfg_term = 4'd6; intf.cfg_reps = 8'd2;
        pulse_start();
        vectors++; if (intf.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %0b want 1", intf.busy); end
        vectors++; if (intf.wraps !== 8'd0) begin miscompares++; $display("FAIL basic_wraps0 got %0d want 0", intf.wraps); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (intf.q_in !== eq[i]) begin miscompares++; $display("FAIL basic_q[%0d] got %0d want %0d", i, intf.q_in, eq[i]); end
            vectors++; if (intf.load !== el[i]) begin miscompares++; $display("FAIL basic_load[%0d] got %0b want %0b", i, intf.load, el[i]); end
            vectors++; if (intf.done !== 1'b0) begin miscompares++; $display("FAIL basic_early_done[%0d] got %0b want 0", i, intf.done); end
            // Config changes mid-run must not disturb the window.
            if (i == 2) begin intf.cfg_start = 4'd8; intf.cfg_term = 4'd12; end
            @(negedge clk);
        end
        vectors++; if (intf.done !== 1'b1) begin miscompares++; $display("FAIL basic_done got %0b want 1", intf.done); end
        vectors++; if (intf.wraps !== 8'd2) begin miscompares++; $display("FAIL basic_wraps got %0d want 2", intf.wraps); end
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %0b want 0", intf.busy); end
        vectors++; if (intf.load !== 1'b1) begin miscompares++; $display("FAIL basic_load_end got %0b want 1", intf.load); end
        vectors++; if (intf.q_in !== 4'd3) begin miscompares++; $display("FAIL basic_q_after got %0d want 3", intf.q_in); end
        @(negedge clk);
        vectors++; if (intf.done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %0b want 0", intf.done); end
        vectors++; if (intf.q_in !== 4'd8) begin miscompares++; $display("FAIL basic_q_idle got %0d want 8", intf.q_in); end
    endtask

    task automatic test_wrap_window();
        logic [3:0] eq [4];
        logic       el [4];
        eq = '{4'd14, 4'd15, 4'd0, 4'd1};
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
        intf.cfg_start = 4'd14; intf.cfg_term = 4'd1; intf.cfg_reps = 8'd1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (intf.q_in !== eq[i]) begin miscompares++; $display("FAIL wrap_q[%0d] got %0d want %0d", i, intf.q_in, eq[i]); end
            vectors++; if (intf.load !== el[i]) begin miscompares++; $display("FAIL wrap_load[%0d] got %0b want %0b", i, intf.load, el[i]); end
            @(negedge clk);
        end
        vectors++; if (intf.done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %0b want 1", intf.done); end
        vectors++; if (intf.wraps !== 8'd1) begin miscompares++; $display("FAIL wrap_wraps got %0d want 1", intf.wraps); end
        vectors++; if (intf.err !== 1'b0) begin miscompares++; $display("FAIL wrap_err got %0b want 0", intf.err); end
        @(negedge clk);
    endtask

    task automatic test_equal_window();
        intf.cfg_start = 4'd5; intf.cfg_term = 4'd5; intf.cfg_reps = 8'd3;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (intf.q_in !== 4'd5) begin miscompares++; $display("FAIL eq_q[%0d] got %0d want 5", i, intf.q_in); end
            vectors++; if (intf.load !== 1'b1) begin miscompares++; $display("FAIL eq_load[%0d] got %0b want 1", i, intf.load); end
            vectors++; if (intf.wraps !== 8'(i)) begin miscompares++; $display("FAIL eq_wraps[%0d] got %0d want %0d", i, intf.wraps, i); end
            vectors++; if (intf.busy !== 1'b1) begin miscompares++; $display("FAIL eq_busy[%0d] got %0b want 1", i, intf.busy); end
            @(negedge clk);
        end
        vectors++; if (intf.done !== 1'b1) begin miscompares++; $display("FAIL eq_done got %0b want 1", intf.done); end
        vectors++; if (intf.wraps !== 8'd3) begin miscompares++; $display("FAIL eq_wraps_end got %0d want 3", intf.wraps); end
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL eq_busy_end got %0b want 0", intf.busy); end
        @(negedge clk);
    endtask

    task automatic test_stop();
        intf.cfg_start = 4'd0; intf.cfg_term = 4'd9; intf.cfg_reps = 8'd0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (intf.q_in !== 4'(i)) begin miscompares++; $display("FAIL stop_q[%0d] got %0d want %0d", i, intf.q_in, i); end
            if (i == 4) intf.stop = 1'b1;
            @(negedge clk);
        end
        intf.stop = 1'b0;
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy got %0b want 0", intf.busy); end
        vectors++; if (intf.load !== 1'b1) begin miscompares++; $display("FAIL stop_load got %0b want 1", intf.load); end
        vectors++; if (intf.done !== 1'b0) begin miscompares++; $display("FAIL stop_done got %0b want 0", intf.done); end
        vectors++; if (intf.wraps !== 8'd0) begin miscompares++; $display("FAIL stop_wraps got %0d want 0", intf.wraps); end
        @(negedge clk);
        vectors++; if (intf.q_in !== 4'd0) begin miscompares++; $display("FAIL stop_q_idle got %0d want 0", intf.q_in); end
        // start and stop together in IDLE: no run.
        intf.start = 1'b1; intf.stop = 1'b1;
        @(negedge clk);
        intf.start = 1'b0; intf.stop = 1'b0;
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL startstop_busy got %0b want 0", intf.busy); end
        intf.cfg_reps = 8'd1;
        pulse_start();
        vectors++; if (intf.wraps !== 8'd0) begin miscompares++; $display("FAIL rerun_wraps0 got %0d want 0", intf.wraps); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (intf.q_in !== 4'(i)) begin miscompares++; $display("FAIL rerun_q[%0d] got %0d want %0d", i, intf.q_in, i); end
            vectors++; if (intf.load !== (i == 9)) begin miscompares++; $display("FAIL rerun_load[%0d] got %0b want %0b", i, intf.load, (i == 9)); end
            @(negedge clk);
        end
        vectors++; if (intf.done !== 1'b1) begin miscompares++; $display("FAIL rerun_done got %0b want 1", intf.done); end
        vectors++; if (intf.wraps !== 8'd1) begin miscompares++; $display("FAIL rerun_wraps got %0d want 1", intf.wraps); end
        @(negedge clk);
    endtask

    task automatic test_clear_midrun();
        intf.cfg_start = 4'd0; intf.cfg_term = 4'd9; intf.cfg_reps = 8'd0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                vectors++; if (intf.q_in !== 4'd7) begin miscompares++; $display("FAIL clr_q7 got %0d want 7", intf.q_in); end
                clear = 1'b1;
            end
            @(negedge clk);
        end
        clear = 1'b0;
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy got %0b want 0", intf.busy); end
        vectors++; if (intf.load !== 1'b1) begin miscompares++; $display("FAIL clr_load got %0b want 1", intf.load); end
        vectors++; if (intf.done !== 1'b0) begin miscompares++; $display("FAIL clr_done got %0b want 0", intf.done); end
        vectors++; if (intf.q_in !== 4'd0) begin miscompares++; $display("FAIL clr_q got %0d want 0", intf.q_in); end
        intf.cfg_start = 4'd2; intf.cfg_term = 4'd4; intf.cfg_reps = 8'd1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (intf.q_in !== 4'(i + 2)) begin miscompares++; $display("FAIL clr_run_q[%0d] got %0d want %0d", i, intf.q_in, i + 2); end
            @(negedge clk);
        end
        vectors++; if (intf.done !== 1'b1) begin miscompares++; $display("FAIL clr_run_done got %0b want 1", intf.done); end
        vectors++; if (intf.err !== 1'b0) begin miscompares++; $display("FAIL clr_run_err got %0b want 0", intf.err); end
        @(negedge clk);
    endtask

    task automatic test_err();
        intf.cfg_start = 4'd3; intf.cfg_term = 4'd6; intf.cfg_reps = 8'd1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                vectors++; if (intf.err !== 1'b0) begin miscompares++; $display("FAIL err_pre got %0b want 0", intf.err); end
                force_val = 4'd2; force_en = 1'b1;
            end
            if (i == 3) begin
                force_en = 1'b0;
                vectors++; if (intf.err !== 1'b1) begin miscompares++; $display("FAIL err_set got %0b want 1", intf.err); end
            end
            @(negedge clk);
        end
        vectors++; if (intf.done !== 1'b1) begin miscompares++; $display("FAIL err_done got %0b want 1", intf.done); end
        vectors++; if (intf.err !== 1'b1) begin miscompares++; $display("FAIL err_hold_end got %0b want 1", intf.err); end
        @(negedge clk);
        pulse_start();
        vectors++; if (intf.err !== 1'b1) begin miscompares++; $display("FAIL err_hold_restart got %0b want 1", intf.err); end
        for (int i = 0; i < 4; i++) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        vectors++; if (intf.err !== 1'b0) begin miscompares++; $display("FAIL err_cleared got %0b want 0", intf.err); end
    endtask

    task automatic test_saturate();
        intf.cfg_start = 4'd0; intf.cfg_term = 4'd0; intf.cfg_reps = 8'd0;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 300; i++) @(negedge clk);
        vectors++; if (intf.wraps !== 8'd255) begin miscompares++; $display("FAIL sat_wraps got %0d want 255", intf.wraps); end
        vectors++; if (intf.busy !== 1'b1) begin miscompares++; $display("FAIL sat_busy got %0b want 1", intf.busy); end
        intf.stop = 1'b1;
        @(negedge clk);
        intf.stop = 1'b0;
        vectors++; if (intf.busy !== 1'b0) begin miscompares++; $display("FAIL sat_stop_busy got %0b want 0", intf.busy); end
        vectors++; if (intf.wraps !== 8'd255) begin miscompares++; $display("FAIL sat_stop_wraps got %0d want 255", intf.wraps); end
        vectors++; if (intf.done !== 1'b0) begin miscompares++; $display("FAIL sat_stop_done got %0b want 0", intf.done); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear = 1'b1;
        force_en = 1'b0;
        force_val = 4'd0;
        intf.start = 1'b0;
        intf.stop = 1'b0;
        intf.cfg_start = 4'd3;
        intf.cfg_term = 4'd6;
        intf.cfg_reps = 8'd2;
        test_reset();
        test_basic_window();
        test_wrap_window();
        test_equal_window();
        test_stop();
        test_clear_midrun();
        test_err();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
